// File: rtl/svn_seg_pkg.sv
// Glyph codes, segment patterns and the code-to-pattern decode shared by the
// seven-segment scanner.
package svn_seg_pkg;

   localparam logic [3:0] CODE_O     = 4'd0;
   localparam logic [3:0] CODE_1     = 4'd1;
   localparam logic [3:0] CODE_2     = 4'd2;
   localparam logic [3:0] CODE_3     = 4'd3;
   localparam logic [3:0] CODE_4     = 4'd4;
   localparam logic [3:0] CODE_DASH  = 4'd5;
   localparam logic [3:0] CODE_E     = 4'd6;
   localparam logic [3:0] CODE_N     = 4'd7;
   localparam logic [3:0] CODE_F     = 4'd8;
   localparam logic [3:0] CODE_U     = 4'd9;
   localparam logic [3:0] CODE_L     = 4'd10;
   localparam logic [3:0] CODE_P     = 4'd11;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   // Segment order a..g, MSB = a, active-low.
   localparam logic [6:0] SEG_O    = 7'b0000001;
   localparam logic [6:0] SEG_1    = 7'b1001111;
   localparam logic [6:0] SEG_2    = 7'b0010010;
   localparam logic [6:0] SEG_3    = 7'b0000110;
   localparam logic [6:0] SEG_4    = 7'b1001100;
   localparam logic [6:0] SEG_DASH = 7'b1111110;
   localparam logic [6:0] SEG_E    = 7'b0110000;
   localparam logic [6:0] SEG_N    = 7'b0001001;
   localparam logic [6:0] SEG_F    = 7'b0111000;
   localparam logic [6:0] SEG_U    = 7'b1000001;
   localparam logic [6:0] SEG_L    = 7'b1110001;
   localparam logic [6:0] SEG_P    = 7'b0011000;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   function automatic logic [6:0] glyph_decode(input logic [3:0] code);
      logic [6:0] pattern;
      case (code)
         CODE_O:    pattern = SEG_O;
         CODE_1:    pattern = SEG_1;
         CODE_2:    pattern = SEG_2;
         CODE_3:    pattern = SEG_3;
         CODE_4:    pattern = SEG_4;
         CODE_DASH: pattern = SEG_DASH;
         CODE_E:    pattern = SEG_E;
         CODE_N:    pattern = SEG_N;
         CODE_F:    pattern = SEG_F;
         CODE_U:    pattern = SEG_U;
         CODE_L:    pattern = SEG_L;
         CODE_P:    pattern = SEG_P;
         default:   pattern = SEG_OFF;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/svn_glyph_rom.sv
// Combinational glyph lookup: 4-bit code to active-low segment pattern.
module svn_glyph_rom
   import svn_seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] pattern
);

   assign pattern = glyph_decode(code);

endmodule

// File: rtl/svn_seg_scan.sv
// Time-multiplexed seven-segment scanner with frame-aligned updates, per-digit
// blank/blink/decimal point and an anode dead time at the start of each slot.
module svn_seg_scan
   import svn_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned DEAD_CYCLES  = 16,
   parameter int unsigned BLINK_FRAMES = 250
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] codes,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [SW-1:0] slot_cnt;
   logic [DW-1:0] dig_idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_on;

   logic [4*NUM_DIGITS-1:0] pend_codes, act_codes;
   logic [NUM_DIGITS-1:0]   pend_dp, pend_blank, pend_blink;
   logic [NUM_DIGITS-1:0]   act_dp, act_blank, act_blink;
   logic                    pend_valid;

   logic                  slot_last, dig_last, blink_last, boundary, live, dark;
   logic [3:0]            cur_code;
   logic [6:0]            cur_glyph;
   logic [NUM_DIGITS-1:0] an_nxt;
   logic [6:0]            seg_nxt;
   logic                  dp_nxt;

   assign slot_last  = (slot_cnt == SW'(REFRESH_DIV - 1));
   assign dig_last   = (dig_idx == DW'(NUM_DIGITS - 1));
   assign blink_last = (blink_cnt == BW'(BLINK_FRAMES - 1));
   assign boundary   = en & slot_last & dig_last;
   assign live       = (32'(slot_cnt) >= DEAD_CYCLES);

   assign cur_code = act_codes[{dig_idx, 2'b00} +: 4];

   svn_glyph_rom u_glyph_rom (
      .code    (cur_code),
      .pattern (cur_glyph)
   );

   assign dark = !live | act_blank[dig_idx] | (act_blink[dig_idx] & !blink_on);

   always_comb begin
      an_nxt = '1;
      if (en && live) an_nxt[dig_idx] = 1'b0;
      seg_nxt = (!en || dark) ? SEG_OFF : cur_glyph;
      dp_nxt  = (!en || dark) ? 1'b1 : !act_dp[dig_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt  <= '0;
         dig_idx   <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (en) begin
         if (slot_last) begin
            slot_cnt <= '0;
            dig_idx  <= dig_last ? '0 : dig_idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
         if (boundary) begin
            if (blink_last) begin
               blink_cnt <= '0;
               blink_on  <= !blink_on;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // A load landing on the frame boundary bypasses pending and wins over it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_codes <= '1;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_blink <= '0;
         pend_valid <= 1'b0;
         act_codes  <= '1;
         act_dp     <= '0;
         act_blank  <= '0;
         act_blink  <= '0;
      end else if (load && boundary) begin
         act_codes  <= codes;
         act_dp     <= dp_mask;
         act_blank  <= blank_mask;
         act_blink  <= blink_mask;
         pend_valid <= 1'b0;
      end else begin
         if (boundary && pend_valid) begin
            act_codes  <= pend_codes;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            act_blink  <= pend_blink;
            pend_valid <= 1'b0;
         end
         if (load) begin
            pend_codes <= codes;
            pend_dp    <= dp_mask;
            pend_blank <= blank_mask;
            pend_blink <= blink_mask;
            pend_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         an         <= an_nxt;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_svn_seg_scan.sv
// Scoreboard bench for svn_seg_scan: a cycle model queues the expected outputs
// of every enabled cycle, and directed checks cover the visible display effects.
module tb_svn_seg_scan;

   logic        clk, rst_n, en, load;
   logic [15:0] codes;
   logic [3:0]  dp_mask, blank_mask, blink_mask;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] glyph_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b1111110, 7'b0110000, 7'b0001001,
      7'b0111000, 7'b1000001, 7'b1110001, 7'b0011000,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

   logic [12:0] exp_q [$];

   svn_seg_scan #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .DEAD_CYCLES  (1),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load       (load),
      .codes      (codes),
      .dp_mask    (dp_mask),
      .blank_mask (blank_mask),
      .blink_mask (blink_mask),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of the scanner state.
   int          m_slot, m_dig, m_bcnt;
   logic        m_bon, m_pv;
   logic [15:0] p_codes, a_codes;
   logic [3:0]  p_dp, p_blank, p_blink, a_dp, a_blank, a_blink;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_slot = 0; m_dig = 0; m_bcnt = 0; m_bon = 1'b1; m_pv = 1'b0;
            p_codes = 16'hFFFF; a_codes = 16'hFFFF;
            p_dp = '0; p_blank = '0; p_blink = '0;
            a_dp = '0; a_blank = '0; a_blink = '0;
            exp_q.delete();
         end else begin
            logic       live, dark, bnd;
            logic [3:0] an_e, code;
            logic [6:0] seg_e;
            logic       dp_e;
            live  = (m_slot >= 1);
            dark  = !live || a_blank[m_dig] || (a_blink[m_dig] && !m_bon);
            code  = a_codes[m_dig*4 +: 4];
            an_e  = (en && live) ? ~(4'b0001 << m_dig) : 4'hF;
            seg_e = (!en || dark) ? 7'h7F : glyph_tab[code];
            dp_e  = (!en || dark) ? 1'b1 : !a_dp[m_dig];
            bnd   = en && (m_slot == 3) && (m_dig == 3);
            exp_q.push_back({bnd, an_e, dp_e, seg_e});
            if (en) begin
               m_slot = (m_slot + 1) % 4;
               if (m_slot == 0) m_dig = (m_dig + 1) % 4;
            end
            if (bnd) begin
               if (m_pv) begin
                  a_codes = p_codes; a_dp = p_dp; a_blank = p_blank; a_blink = p_blink;
                  m_pv = 1'b0;
               end
               m_bcnt = (m_bcnt + 1) % 2;
               if (m_bcnt == 0) m_bon = !m_bon;
            end
            if (load && bnd) begin
               a_codes = codes; a_dp = dp_mask; a_blank = blank_mask; a_blink = blink_mask;
               m_pv = 1'b0;
            end else if (load) begin
               p_codes = codes; p_dp = dp_mask; p_blank = blank_mask; p_blink = blink_mask;
               m_pv = 1'b1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            logic [12:0] e;
            e = exp_q.pop_front();
            check("scan", {19'd0, frame_done, an, dp, seg}, {19'd0, e});
         end
      end
   end

   task automatic do_load(input logic [15:0] c, input logic [3:0] dpm, input logic [3:0] bm,
                          input logic [3:0] blm);
      codes = c; dp_mask = dpm; blank_mask = bm; blink_mask = blm;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      logic found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (frame_done) found = 1'b1;
      end
      check(tag, {31'd0, found}, 32'd1);
   endtask

   task automatic wait_an(input string tag, input logic [3:0] pat);
      logic found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (an == pat) found = 1'b1;
      end
      check(tag, {31'd0, found}, 32'd1);
   endtask

   initial begin
      int cnt, cnt2, vis;
      rst_n = 1'b0; en = 1'b0; load = 1'b0;
      codes = '0; dp_mask = '0; blank_mask = '0; blink_mask = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_dp", {31'd0, dp}, 32'd1);
      check("rst_fd", {31'd0, frame_done}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1; en = 1'b1;
      cnt = 0;
      repeat (32) begin
         @(negedge clk);
         cnt += int'(frame_done);
      end
      check("fd_rate", cnt, 2);

      // "P-EN" loaded mid-frame, visible from the next frame.
      repeat (5) @(negedge clk);
      do_load(16'hB567, 4'b0000, 4'b0000, 4'b0000);
      wait_frame("wait_pen");
      wait_an("an_d0", 4'b1110);
      check("pen_d0", {25'd0, seg}, {25'd0, 7'b0001001});
      wait_an("an_d1", 4'b1101);
      check("pen_d1", {25'd0, seg}, {25'd0, 7'b0110000});
      wait_an("an_d2", 4'b1011);
      check("pen_d2", {25'd0, seg}, {25'd0, 7'b1111110});
      wait_an("an_d3", 4'b0111);
      check("pen_d3", {25'd0, seg}, {25'd0, 7'b0011000});

      // Two loads in one frame: last wins.
      wait_frame("wait_2ld");
      repeat (3) @(negedge clk);
      do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
      repeat (4) @(negedge clk);
      do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
      cnt = 0; cnt2 = 0;
      repeat (48) begin
         @(negedge clk);
         if (seg == 7'b1001111) cnt++;
         if (seg == 7'b0010010) cnt2++;
      end
      check("no_one", cnt, 0);
      check("two_seen", {31'd0, cnt2 > 0}, 32'd1);

      // Load coincident with the boundary goes straight to active.
      wait_frame("wait_bnd");
      repeat (15) @(negedge clk);
      do_load(16'h3333, 4'b0000, 4'b0000, 4'b0000);
      check("bnd_align", {31'd0, frame_done}, 32'd1);
      wait_an("an_bnd", 4'b1110);
      check("bnd_d0", {25'd0, seg}, {25'd0, 7'b0000110});

      // Blink on digit 0, blank on digit 1.
      do_load(16'h1110, 4'b0000, 4'b0010, 4'b0001);
      wait_frame("wait_blink");
      vis = 0;
      for (int f = 0; f < 8; f++) begin
         wait_an("an_bl0", 4'b1110);
         if (seg == 7'b0000001) vis++;
         wait_an("an_bl1", 4'b1101);
         check("blank_d1", {25'd0, seg}, 32'h7F);
         wait_an("an_bl2", 4'b1011);
         check("blink_d2", {25'd0, seg}, {25'd0, 7'b1001111});
      end
      check("blink_vis", vis, 4);

      // Decimal point on digit 2 only while its anode is live.
      do_load(16'h1110, 4'b0100, 4'b0000, 4'b0000);
      wait_frame("wait_dp1");
      wait_frame("wait_dp2");
      cnt = 0; cnt2 = 0;
      repeat (16) begin
         @(negedge clk);
         if (!dp) cnt++;
         if (!dp && an != 4'b1011) cnt2++;
      end
      check("dp_cnt", cnt, 3);
      check("dp_stray", cnt2, 0);

      // Enable dropped mid-slot.
      repeat (6) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("en_off_an", {28'd0, an}, 32'hF);
      repeat (5) @(negedge clk);
      en = 1'b1;
      repeat (40) @(negedge clk);

      // Asynchronous reset mid-frame.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_an", {28'd0, an}, 32'hF);
      check("arst_seg", {25'd0, seg}, 32'h7F);
      check("arst_dp", {31'd0, dp}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (seg != 7'h7F) cnt++;
      end
      check("post_rst_blank", cnt, 0);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/svn_seg_scan.md
Name: svn_seg_scan

Overview:
- Multiplexed, parametrised successor to the single-digit glyph decoder.
- Drives NUM_DIGITS common-anode seven-segment digits from one shared active-low segment bus.
- Adds time-multiplexed scanning, frame-aligned data update, per-digit blanking, blinking and decimal point, and anti-ghost dead time.
- Sits between the parking controller's status/count logic and the board's display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..8).
- REFRESH_DIV, 50000: clock cycles per digit slot (>= DEAD_CYCLES+1).
- DEAD_CYCLES, 16: cycles at the start of each slot with all anodes off (0 allowed).
- BLINK_FRAMES, 250: full scan frames per blink half-period (>= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = display dark, counters hold.
- load  in  1  single-cycle strobe; captures codes, dp_mask, blank_mask, blink_mask.
- codes  in  4*NUM_DIGITS  glyph code per digit; digit i = codes[4i+3:4i].
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i.
- blank_mask  in  NUM_DIGITS  1 = digit i forced dark.
- blink_mask  in  NUM_DIGITS  1 = digit i dark during blink-off phase.
- seg  out  7  segments a..g, MSB = a, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anode enables, active-low.
- frame_done  out  1  one-cycle pulse at end of each full frame.

Behaviour:
- Glyph table (code -> seg):
  - 0 "O" 0000001
  - 1 1001111
  - 2 0010010
  - 3 0000110
  - 4 1001100
  - 5 "-" 1111110
  - 6 "E" 0110000
  - 7 "N" 0001001
  - 8 "F" 0111000
  - 9 "U" 1000001
  - 10 "L" 1110001
  - 11 "P" 0011000
  - 12..15 blank 1111111
- Registers:
  - slot_cnt: 0..REFRESH_DIV-1.
  - dig_idx: 0..NUM_DIGITS-1.
  - blink_cnt: 0..BLINK_FRAMES-1.
  - blink_on: 1 = visible phase.
  - Pending set: loaded by load.
  - Active set: drives the display.
  - pend_valid flag.
- Reset values:
  - seg=7'h7F, dp=1, an=all 1, frame_done=0.
  - slot_cnt=0, dig_idx=0, blink_cnt=0, blink_on=1, pend_valid=0.
  - Active and pending codes all 4'hF; all masks 0.
- Scan (en=1):
  - slot_cnt increments each cycle; at REFRESH_DIV-1 it wraps to 0 and dig_idx advances.
  - dig_idx wraps NUM_DIGITS-1 -> 0; that wrap is the frame boundary.
- Frame boundary, same cycle:
  - frame_done pulses on the next cycle.
  - If pend_valid, pending is copied to active and pend_valid clears.
  - blink_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
- Load handling:
  - load captures inputs into pending and sets pend_valid. A later load before the boundary overwrites pending (last wins).
  - load in the boundary cycle: the captured data goes to active directly in that cycle (takes effect for the frame starting next), and pend_valid stays 0.
- Outputs are registered, with 1-cycle latency from the counter state:
  - an[i]=0 iff en and i==dig_idx and slot_cnt>=DEAD_CYCLES; otherwise 1.
  - seg=glyph(active code[dig_idx]) unless blank_mask[dig_idx], or (blink_mask[dig_idx] and !blink_on), or dead time; those cases give 7'h7F.
  - dp=!dp_mask[dig_idx] under the same dark conditions (dark -> 1).
- en=0:
  - All counters hold; an, seg and dp go all 1 on the next cycle; frame_done stays 0.
  - load still captures into pending.
  - When en returns, scan resumes from the held state.
- Reset mid-scan: all outputs go to reset values immediately (asynchronously) and the display goes dark; pending data is lost.

Decomposition:
- Package svn_seg_pkg:
  - Glyph code localparams: CODE_O, CODE_DASH, CODE_E, CODE_N, CODE_F, CODE_U, CODE_L, CODE_P, CODE_BLANK=15.
  - 7-bit segment pattern constants.
  - SEG_OFF=7'h7F.
  - A decode function code -> pattern.
- One combinational sub-module, svn_glyph_rom: 4-bit code in, 7-bit pattern out. The scan datapath instantiates it once on the muxed active code.

Test Plan (all with NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2):
- Reset then en=1 with no load -> an cycles 1110,1101,1011,0111, each active for 3 cycles after 1 dark cycle; seg=7'h7F throughout; frame_done pulses every 16 cycles.
- load codes={11,5,6,7} ("P-EN" read from digit 3 down) mid-frame -> no change until frame_done; next frame digit0 seg=0001001, digit1 0110000, digit2 1111110, digit3 0011000.
- Two loads in one frame (first all 4'h1, then all 4'h2) -> only 0010010 ever appears; load coincident with the frame boundary -> new codes visible starting at digit0 of the next frame.
- blink_mask=4'b0001, codes digit0=0 -> digit0 shows 0000001 for 2 frames, 7'h7F for 2 frames, repeating; other digits unaffected; blank_mask=4'b0010 -> digit1 always 7'h7F.
- dp_mask=4'b0100 -> dp=0 only while an=1011 and past dead time; en dropped mid-slot -> an=1111 the next cycle; on re-enable, scan resumes at the same digit and slot.
- Assert rst_n low mid-frame -> an, seg and dp all 1 with no clock edge; after release, the active codes show blank.
